// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage (port C) and a
// debug/loader master (port D). C normally wins; D is forced after STARVE_LIMIT consecutive
// C grants while D waits. cpu_stall freezes the pipeline until C's access completes.
// Optional feature: define DMEM_ARB_TIMEOUT_EN to abort accesses whose mem_ready never arrives
// within TIMEOUT cycles (sets sticky err, returns rdata=0).
module dmem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // port C: pipeline MEM stage
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_done,
   output logic [DATA_W-1:0] c_rdata,
   output logic              cpu_stall,
   // port D: debug/loader master
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   // memory side
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              err
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;   // 1: D owns the current access
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]       starve_q, starve_d;
   logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                err_q, err_d;
`endif

   // State and command registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         starve_q  <= '0;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
         tmo_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         starve_q  <= starve_d;
         c_rdata_q <= c_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef DMEM_ARB_TIMEOUT_EN
         tmo_q     <= tmo_d;
         err_q     <= err_d;
`endif
      end
   end

   // Next-state: arbitration in idle, wait for memory in access, one response cycle
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      starve_d  = starve_q;
      c_rdata_d = c_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef DMEM_ARB_TIMEOUT_EN
      tmo_d     = tmo_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (d_req && (!c_req || starve_q == StarveMax)) begin
               owner_d  = 1'b1;
               we_d     = d_we;
               addr_d   = d_addr;
               wdata_d  = d_wdata;
               starve_d = '0;
               state_d  = StAcc;
            end else if (c_req) begin
               owner_d  = 1'b0;
               we_d     = c_we;
               addr_d   = c_addr;
               wdata_d  = c_wdata;
               state_d  = StAcc;
               if (d_req) begin
                  starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
               end else begin
                  starve_d = '0;
               end
            end else begin
               // Reaching here implies d_req is low
               starve_d = '0;
            end
`ifdef DMEM_ARB_TIMEOUT_EN
            tmo_d = '0;
`endif
         end
         StAcc: begin
            if (mem_ready) begin
               if (owner_q) d_rdata_d = mem_rdata;
               else         c_rdata_d = mem_rdata;
               state_d = StResp;
`ifdef DMEM_ARB_TIMEOUT_EN
            end else if (tmo_q == TmoLast) begin
               if (owner_q) d_rdata_d = '0;
               else         c_rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mem_en    = (state_q == StAcc);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign c_done    = (state_q == StResp) & ~owner_q;
   assign d_done    = (state_q == StResp) &  owner_q;
   assign c_rdata   = c_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign cpu_stall = c_req & ~c_done;

`ifdef DMEM_ARB_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
